// File: rtl/dma_ctrl.sv
// Single-channel memory-to-memory DMA engine: reads bursts of up to MAX_BURST words
// over an AXI read master, then writes them back out over an AXI write master.
module dma_ctrl #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DMAEN,
  input  logic [31:0] DMASRC,
  input  logic [31:0] DMADST,
  input  logic [31:0] DMALEN,
  output logic        DMA_done,
  output logic        DMA_err,
  output logic [3:0]  M_ARID,
  output logic [31:0] M_ARAddr,
  output logic [3:0]  M_ARLen,
  output logic [2:0]  M_ARSize,
  output logic [1:0]  M_ARBurst,
  output logic        M_ARValid,
  input  logic        M_ARReady,
  input  logic [3:0]  M_RID,
  input  logic [31:0] M_RData,
  input  logic [1:0]  M_RResp,
  input  logic        M_RLast,
  input  logic        M_RValid,
  output logic        M_RReady,
  output logic [3:0]  M_AWID,
  output logic [31:0] M_AWAddr,
  output logic [3:0]  M_AWLen,
  output logic [2:0]  M_AWSize,
  output logic [1:0]  M_AWBurst,
  output logic        M_AWValid,
  input  logic        M_AWReady,
  output logic [31:0] M_WData,
  output logic [3:0]  M_WStrb,
  output logic        M_WLast,
  output logic        M_WValid,
  input  logic        M_WReady,
  input  logic [3:0]  M_BID,
  input  logic [1:0]  M_BResp,
  input  logic        M_BValid,
  output logic        M_BReady
);
  localparam int unsigned IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, DONE} state_t;

  state_t        state;
  logic [31:0]   src, dst, remaining;
  logic [4:0]    beats;
  logic [IW-1:0] rcnt, wcnt;
  logic [31:0]   buffer [MAX_BURST];

  logic [31:0]   step, rem_after;
  logic [4:0]    nb_start, nb_after, wnext;
  logic          b_err;
  logic          unused_ids;

  function automatic logic [4:0] burst_of(input logic [31:0] rem);
    return (rem > 32'(MAX_BURST)) ? 5'(MAX_BURST) : rem[4:0];
  endfunction

  assign M_ARID    = '0;
  assign M_ARSize  = 3'b010;
  assign M_ARBurst = 2'b01;
  assign M_AWID    = '0;
  assign M_AWSize  = 3'b010;
  assign M_AWBurst = 2'b01;
  assign M_WStrb   = '1;

  assign unused_ids = ^{M_RID, M_BID};

  assign step      = {25'd0, beats, 2'b00};
  assign rem_after = remaining - {27'd0, beats};
  assign nb_start  = burst_of(DMALEN);
  assign nb_after  = burst_of(rem_after);
  assign wnext     = 5'(wcnt) + 5'd1;
  assign b_err     = (M_BResp != 2'b00);

  // Burst staging buffer; contents are don't-care outside a burst, so no reset.
  always_ff @(posedge clk) begin
    if (state == RDATA && M_RValid && M_RReady)
      buffer[rcnt] <= M_RData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      beats     <= '0;
      rcnt      <= '0;
      wcnt      <= '0;
      DMA_done  <= 1'b0;
      DMA_err   <= 1'b0;
      M_ARAddr  <= '0;
      M_ARLen   <= '0;
      M_ARValid <= 1'b0;
      M_RReady  <= 1'b0;
      M_AWAddr  <= '0;
      M_AWLen   <= '0;
      M_AWValid <= 1'b0;
      M_WData   <= '0;
      M_WLast   <= 1'b0;
      M_WValid  <= 1'b0;
      M_BReady  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (DMAEN) begin
            src       <= DMASRC;
            dst       <= DMADST;
            remaining <= DMALEN;
            DMA_err   <= 1'b0;
            if (DMALEN == '0) begin
              state    <= DONE;
              DMA_done <= 1'b1;
            end else begin
              state     <= RADDR;
              M_ARValid <= 1'b1;
              M_ARAddr  <= DMASRC;
              M_ARLen   <= 4'(nb_start - 5'd1);
              beats     <= nb_start;
            end
          end
        end
        RADDR: begin
          if (M_ARReady) begin
            M_ARValid <= 1'b0;
            M_RReady  <= 1'b1;
            rcnt      <= '0;
            state     <= RDATA;
          end
        end
        RDATA: begin
          if (M_RValid) begin
            rcnt <= rcnt + 1'b1;
            if (M_RResp != 2'b00) DMA_err <= 1'b1;
            if (M_RLast) begin
              M_RReady  <= 1'b0;
              M_AWValid <= 1'b1;
              M_AWAddr  <= dst;
              M_AWLen   <= 4'(beats - 5'd1);
              state     <= WADDR;
            end
          end
        end
        WADDR: begin
          if (M_AWReady) begin
            M_AWValid <= 1'b0;
            M_WValid  <= 1'b1;
            M_WData   <= buffer[0];
            M_WLast   <= (beats == 5'd1);
            wcnt      <= '0;
            state     <= WDATA;
          end
        end
        WDATA: begin
          if (M_WReady) begin
            if (M_WLast) begin
              M_WValid <= 1'b0;
              M_WLast  <= 1'b0;
              M_BReady <= 1'b1;
              state    <= WRESP;
            end else begin
              wcnt    <= wcnt + 1'b1;
              M_WData <= buffer[wcnt + 1'b1];
              M_WLast <= (wnext == beats - 5'd1);
            end
          end
        end
        WRESP: begin
          if (M_BValid) begin
            M_BReady  <= 1'b0;
            src       <= src + step;
            dst       <= dst + step;
            remaining <= rem_after;
            if (b_err) DMA_err <= 1'b1;
            // Priority: finished, then disabled, then error stop, else next burst.
            if (rem_after == '0) begin
              state    <= DONE;
              DMA_done <= 1'b1;
            end else if (!DMAEN) begin
              state <= IDLE;
            end else if (DMA_err || b_err) begin
              state    <= DONE;
              DMA_done <= 1'b1;
            end else begin
              state     <= RADDR;
              M_ARValid <= 1'b1;
              M_ARAddr  <= src + step;
              M_ARLen   <= 4'(nb_after - 5'd1);
              beats     <= nb_after;
            end
          end
        end
        DONE: begin
          if (!DMAEN) begin
            DMA_done <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: an AXI memory slave with optional random stalls feeds the DMA,
// and every transfer is compared against burst/data lists computed from the copy rules.
module tb_dma_ctrl;
  localparam int unsigned MB = 4;

  logic        clk, rst;
  logic        DMAEN;
  logic [31:0] DMASRC, DMADST, DMALEN;
  logic        DMA_done, DMA_err;
  logic [3:0]  M_ARID, M_ARLen, M_AWID, M_AWLen, M_WStrb, M_RID, M_BID;
  logic [31:0] M_ARAddr, M_AWAddr, M_RData, M_WData;
  logic [2:0]  M_ARSize, M_AWSize;
  logic [1:0]  M_ARBurst, M_AWBurst, M_RResp, M_BResp;
  logic        M_ARValid, M_ARReady, M_RLast, M_RValid, M_RReady;
  logic        M_AWValid, M_AWReady, M_WLast, M_WValid, M_WReady, M_BValid, M_BReady;

  dma_ctrl #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .DMAEN(DMAEN), .DMASRC(DMASRC), .DMADST(DMADST), .DMALEN(DMALEN),
    .DMA_done(DMA_done), .DMA_err(DMA_err),
    .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen), .M_ARSize(M_ARSize),
    .M_ARBurst(M_ARBurst), .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
    .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
    .M_RValid(M_RValid), .M_RReady(M_RReady),
    .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen), .M_AWSize(M_AWSize),
    .M_AWBurst(M_AWBurst), .M_AWValid(M_AWValid), .M_AWReady(M_AWReady),
    .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast), .M_WValid(M_WValid),
    .M_WReady(M_WReady), .M_BID(M_BID), .M_BResp(M_BResp), .M_BValid(M_BValid),
    .M_BReady(M_BReady)
  );

  int total = 0;
  int bad = 0;

  int          stall = 0;
  int          err_burst = -1;
  int          b_count = 0;
  logic [31:0] mem_seed = 32'h1234_5678;

  logic [31:0] ar_addr_q[$], aw_addr_q[$], wr_addr_q[$], wr_data_q[$];
  logic [3:0]  ar_len_q[$], aw_len_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] data_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  function automatic logic rnd_ready();
    return (stall == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
  endfunction

  // AXI memory slave; decisions are made at the falling edge, so every handshake
  // that will occur at the next rising edge is known (and logged) here.
  initial begin
    logic [31:0] r_addr, w_addr, ar_hold_addr, w_hold_data;
    logic [3:0]  w_len, ar_hold_len;
    int          r_left, w_beat;
    bit          w_open, b_pend, ar_hold, w_hold, r_hold;
    M_ARReady = 0; M_RID = '0; M_RData = '0; M_RResp = '0; M_RLast = 0; M_RValid = 0;
    M_AWReady = 0; M_WReady = 0; M_BID = '0; M_BResp = '0; M_BValid = 0;
    r_addr = '0; w_addr = '0; w_len = '0; r_left = 0; w_beat = 0;
    w_open = 0; b_pend = 0; ar_hold = 0; w_hold = 0; r_hold = 0;
    ar_hold_addr = '0; ar_hold_len = '0; w_hold_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        M_ARReady = 0; M_RValid = 0; M_RLast = 0; M_AWReady = 0; M_WReady = 0; M_BValid = 0;
        r_left = 0; w_open = 0; b_pend = 0; ar_hold = 0; w_hold = 0; r_hold = 0; b_count = 0;
      end else begin
        if (ar_hold) begin
          check("ar_hold_valid", M_ARValid, 1);
          check("ar_hold_addr", M_ARAddr, ar_hold_addr);
          check("ar_hold_len", M_ARLen, ar_hold_len);
        end
        if (w_hold) begin
          check("w_hold_valid", M_WValid, 1);
          check("w_hold_data", M_WData, w_hold_data);
        end
        // Read data channel
        if (r_left > 0) begin
          M_RValid = r_hold ? 1'b1 : rnd_ready();
          M_RData  = data_at(r_addr);
          M_RLast  = (r_left == 1);
          M_RResp  = 2'b00;
          r_hold   = M_RValid && !M_RReady;
          if (M_RValid && M_RReady) begin
            r_addr += 4;
            r_left--;
          end
        end else begin
          M_RValid = 0;
          M_RLast  = 0;
          r_hold   = 0;
        end
        // Read address channel
        M_ARReady = (r_left == 0) && rnd_ready();
        ar_hold = M_ARValid && !M_ARReady;
        ar_hold_addr = M_ARAddr;
        ar_hold_len  = M_ARLen;
        if (M_ARValid && M_ARReady) begin
          ar_addr_q.push_back(M_ARAddr);
          ar_len_q.push_back(M_ARLen);
          r_addr = M_ARAddr;
          r_left = int'(M_ARLen) + 1;
        end
        // Write response channel
        if (b_pend) begin
          M_BValid = rnd_ready();
          M_BResp  = (b_count == err_burst) ? 2'b10 : 2'b00;
          if (M_BValid && M_BReady) begin
            b_pend = 0;
            b_count++;
          end
        end else begin
          M_BValid = 0;
        end
        // Write data channel
        M_WReady = w_open && rnd_ready();
        w_hold = M_WValid && !M_WReady;
        w_hold_data = M_WData;
        if (M_WValid && M_WReady) begin
          wr_addr_q.push_back(w_addr);
          wr_data_q.push_back(M_WData);
          check("wlast", M_WLast, (w_beat == int'(w_len)));
          w_addr += 4;
          w_beat++;
          if (M_WLast) begin
            w_open = 0;
            b_pend = 1;
          end
        end
        // Write address channel
        M_AWReady = !w_open && !b_pend && rnd_ready();
        if (M_AWValid && M_AWReady) begin
          aw_addr_q.push_back(M_AWAddr);
          aw_len_q.push_back(M_AWLen);
          w_open = 1;
          w_addr = M_AWAddr;
          w_len  = M_AWLen;
          w_beat = 0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    DMAEN = 0;
    repeat (2) tick();
    rst = 0;
  endtask

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); aw_addr_q.delete(); aw_len_q.delete();
    wr_addr_q.delete(); wr_data_q.delete();
  endtask

  task automatic run(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                     input int stl, input int errb, input bit drop_en, input bit do_rst);
    logic [31:0] e_addr[$];
    logic [3:0]  e_len[$];
    logic [31:0] rem, a, b;
    int          nw, n;
    bit          to;
    if (do_rst) do_reset();
    clear_logs();
    stall = stl;
    err_burst = errb;
    b_count = 0;
    mem_seed = $urandom;
    // Expected bursts: chunks of up to MB words; stop early after an error or disable.
    rem = len; a = src; nw = 0;
    while (rem != 0) begin
      b = (rem > 32'(MB)) ? 32'(MB) : rem;
      e_addr.push_back(a);
      e_len.push_back(4'(b - 1));
      nw += int'(b);
      a += 4 * b;
      rem -= b;
      if (drop_en || errb == e_addr.size() - 1) break;
    end
    DMASRC = src; DMADST = dst; DMALEN = len; DMAEN = 1;
    tick();
    DMASRC = $urandom; DMADST = $urandom; DMALEN = $urandom;
    n = 0;
    if (drop_en) begin
      while (ar_addr_q.size() == 0 && n < 1000) begin tick(); n++; end
      tick();
      DMAEN = 0;
      while (b_count == 0 && n < 3000) begin tick(); n++; end
      to = (b_count == 0);
      repeat (6) tick();
    end else begin
      while (!DMA_done && n < 5000) begin tick(); n++; end
      to = !DMA_done;
      repeat (3) tick();
    end
    check("finished", {31'd0, to}, 0);
    check("done", DMA_done, drop_en ? 0 : 1);
    check("err", DMA_err, (errb >= 0));
    check("n_ar", ar_addr_q.size(), e_addr.size());
    check("n_aw", aw_addr_q.size(), e_addr.size());
    for (int i = 0; i < e_addr.size() && i < ar_addr_q.size(); i++) begin
      check("ar_addr", ar_addr_q[i], e_addr[i]);
      check("ar_len", ar_len_q[i], e_len[i]);
    end
    for (int i = 0; i < e_addr.size() && i < aw_addr_q.size(); i++) begin
      check("aw_addr", aw_addr_q[i], dst + (e_addr[i] - src));
      check("aw_len", aw_len_q[i], e_len[i]);
    end
    check("n_wr", wr_addr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
      check("wr_addr", wr_addr_q[i], dst + 32'(4 * i));
      check("wr_data", wr_data_q[i], data_at(src + 32'(4 * i)));
    end
    DMAEN = 0;
    repeat (2) tick();
    check("done_clr", DMA_done, 0);
  endtask

  initial begin
    int n;
    rst = 1; DMAEN = 0; DMASRC = '0; DMADST = '0; DMALEN = '0;
    do_reset();
    check("rst_ctl", {M_ARValid, M_RReady, M_AWValid, M_WValid, M_WLast, M_BReady, DMA_done, DMA_err}, 0);
    check("rst_araddr", M_ARAddr, 0);
    check("fixed", {M_ARID, M_ARSize, M_ARBurst, M_AWID, M_AWSize, M_AWBurst, M_WStrb},
          {4'd0, 3'b010, 2'b01, 4'd0, 3'b010, 2'b01, 4'hF});

    run(32'h1000, 32'h2000, 4, 0, -1, 0, 1);
    run(32'h1000, 32'h2000, 10, 0, -1, 0, 1);

    // Zero-length transfer: done on the next cycle, no bus activity, held while enabled
    do_reset();
    clear_logs();
    DMALEN = 0; DMAEN = 1;
    tick();
    check("len0_done", DMA_done, 1);
    tick();
    check("len0_hold", DMA_done, 1);
    check("len0_noar", ar_addr_q.size(), 0);
    DMAEN = 0;
    tick();
    check("len0_clr", DMA_done, 0);

    run(32'h1000, 32'h2000, 7, 1, -1, 0, 1);
    for (int t = 0; t < 4; t++)
      run($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom_range(1, 13), 1, -1, 0, 1);

    run(32'h1000, 32'h2000, 8, 0, 0, 0, 1);
    run(32'h3000, 32'h4000, 3, 1, -1, 0, 0);
    run(32'h1000, 32'h2000, 8, 0, -1, 1, 1);

    // Reset in the middle of the write data phase
    do_reset();
    stall = 0; err_burst = -1;
    DMASRC = 32'h1000; DMADST = 32'h2000; DMALEN = 8; DMAEN = 1;
    n = 0;
    while (!M_WValid && n < 1000) begin tick(); n++; end
    check("wdata_seen", M_WValid, 1);
    rst = 1;
    DMAEN = 0;
    @(posedge clk);
    #1;
    check("midrst_ctl", {M_ARValid, M_RReady, M_AWValid, M_WValid, M_WLast, M_BReady, DMA_done, DMA_err}, 0);
    check("midrst_wdata", M_WData, 0);
    check("midrst_awaddr", M_AWAddr, 0);
    tick();
    rst = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
